// File: rtl/clk_period_meter.sv
// clk_period_meter: Avalon-MM slave that synchronises an external clock/strobe
// pin, measures the period between rising edges in system-clock cycles, counts
// edges, detects loss of signal with a programmable timeout and raises an irq.
module clk_period_meter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_RST = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LIMIT_RST = CNT_W'(TIMEOUT_RST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic             enable_q, enable_d;
  logic             irq_en_q, irq_en_d;
  logic             capture_q, capture_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             cap_set, to_set, edge_inc;
  logic             wr_en;
  logic             unused_wdata;

  assign rise         = s2_q & ~s3_q;
  assign wr_en        = chipselect & ~write_n;
  assign readdata     = readdata_q;
  assign irq          = irq_q;
  // Upper write-data bits are meaningless when CNT_W < 32.
  assign unused_wdata = ^writedata;

  // Two-flop synchroniser plus history flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Measurement FSM: arm on first edge, then time edge-to-edge intervals.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    cap_set  = 1'b0;
    to_set   = 1'b0;
    edge_inc = 1'b0;
    if (!enable_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM: begin
          cnt_d = '0;
          if (rise) begin
            cnt_d    = CNT_ONE;
            edge_inc = 1'b1;
            state_d  = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            // A rise in the same cycle as the limit is a valid edge, not a loss.
            period_d = cnt_q;
            cnt_d    = CNT_ONE;
            cap_set  = 1'b1;
            edge_inc = 1'b1;
          end else if ((limit_q != '0) && (cnt_q == limit_q)) begin
            to_set  = 1'b1;
            cnt_d   = '0;
            state_d = ARM;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Register file next-state, status set/clear priority and read mux.
  always_comb begin
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    limit_d    = limit_q;
    edge_cnt_d = edge_cnt_q;
    if (edge_inc) edge_cnt_d = edge_cnt_q + CNT_ONE;
    // Hardware set wins over a coincident write-1-to-clear.
    capture_d  = cap_set | (capture_q & ~(wr_en && (address == 3'd2) && writedata[0]));
    timeout_d  = to_set  | (timeout_q & ~(wr_en && (address == 3'd2) && writedata[1]));
    if (wr_en) begin
      unique case (address)
        3'd1: begin
          enable_d = writedata[0];
          irq_en_d = writedata[1];
        end
        // Clear wins over a coincident edge: that edge is not counted.
        3'd4:    edge_cnt_d = '0;
        3'd5:    limit_d    = writedata[CNT_W-1:0];
        default: ;
      endcase
    end
    irq_d = irq_en_q & (capture_q | timeout_q);
    unique case (address)
      3'd0:    readdata_d = 32'(s2_q);
      3'd1:    readdata_d = {30'd0, irq_en_q, enable_q};
      3'd2:    readdata_d = {30'd0, timeout_q, capture_q};
      3'd3:    readdata_d = 32'(period_q);
      3'd4:    readdata_d = 32'(edge_cnt_q);
      3'd5:    readdata_d = 32'(limit_q);
      default: readdata_d = 32'd0;
    endcase
  end

  // State and register update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      edge_cnt_q <= '0;
      limit_q    <= LIMIT_RST;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      capture_q  <= 1'b0;
      timeout_q  <= 1'b0;
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      edge_cnt_q <= edge_cnt_d;
      limit_q    <= limit_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      capture_q  <= capture_d;
      timeout_q  <= timeout_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: a 32-bit instance for the main behaviour and a
// 4-bit instance for counter wrap and period saturation.
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs_a, cs_b, write_n;
  logic [31:0] writedata;
  logic        in_a, in_b;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  bit          sel_q[$];

  always #5 clk = ~clk;

  clk_period_meter #(.CNT_W(32), .TIMEOUT_RST(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rdata_a), .irq(irq_a)
  );

  clk_period_meter #(.CNT_W(4), .TIMEOUT_RST(5)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(rdata_b), .irq(irq_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    if (sel) cs_b = 1'b1;
    else     cs_a = 1'b1;
    tick(1);
    write_n = 1'b1;
    cs_a    = 1'b0;
    cs_b    = 1'b0;
  endtask

  // Expected value is queued when the address is presented and compared
  // against readdata once the registered read has been produced.
  task automatic bus_rd(input bit sel, input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    bit          s;
    address = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    tick(1);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    s = sel_q.pop_front();
    check_val(t, s ? rdata_b : rdata_a, e);
  endtask

  task automatic set_in(input bit sel, input bit v);
    if (sel) in_b = v;
    else     in_a = v;
  endtask

  task automatic pulse_train(input bit sel, input int n, input int per);
    repeat (n) begin
      set_in(sel, 1'b1);
      tick(per / 2);
      set_in(sel, 1'b0);
      tick(per - per / 2);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    address   = 3'd0;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
    write_n   = 1'b1;
    writedata = 32'd0;
    in_a      = 1'b0;
    in_b      = 1'b0;
    tick(3);
    check_val("rst_irq", 32'(irq_a), 32'd0);
    check_val("rst_rdata", rdata_a, 32'd0);
    reset_n = 1'b1;
    tick(1);

    // Reset values of the whole register map.
    for (int a = 0; a < 6; a++) bus_rd(1'b0, 3'(a), 32'd0, $sformatf("rst_addr%0d", a));
    bus_rd(1'b1, 3'd5, 32'd5, "rst_limit_b");
    bus_rd(1'b0, 3'd6, 32'd0, "addr6_zero");

    // Synchronised level: visible in s2 two cycles after the pin, read one later.
    set_in(1'b0, 1'b1);
    bus_rd(1'b0, 3'd0, 32'd0, "lvl_c1");
    bus_rd(1'b0, 3'd0, 32'd0, "lvl_c2");
    bus_rd(1'b0, 3'd0, 32'd1, "lvl_c3");
    set_in(1'b0, 1'b0);
    tick(4);
    bus_rd(1'b0, 3'd4, 32'd0, "disabled_no_count");

    // Five rises 20 cycles apart.
    bus_wr(1'b0, 3'd1, 32'd1);
    pulse_train(1'b0, 5, 20);
    bus_rd(1'b0, 3'd3, 32'd20, "period20");
    bus_rd(1'b0, 3'd4, 32'd5, "edges5");
    bus_rd(1'b0, 3'd2, 32'd1, "capture");
    check_val("irq_masked", 32'(irq_a), 32'd0);

    // Interrupt enable, clear and re-assert.
    bus_wr(1'b0, 3'd1, 32'd3);
    tick(1);
    check_val("irq_on", 32'(irq_a), 32'd1);
    bus_wr(1'b0, 3'd2, 32'd1);
    check_val("irq_hold", 32'(irq_a), 32'd1);
    tick(1);
    check_val("irq_off", 32'(irq_a), 32'd0);
    bus_rd(1'b0, 3'd2, 32'd0, "cap_cleared");
    set_in(1'b0, 1'b1);
    tick(3);
    check_val("irq_lat0", 32'(irq_a), 32'd0);
    tick(1);
    check_val("irq_rise", 32'(irq_a), 32'd1);
    set_in(1'b0, 1'b0);
    tick(5);
    // W1C landing on the same edge as a capture.
    set_in(1'b0, 1'b1);
    tick(2);
    bus_wr(1'b0, 3'd2, 32'd1);
    bus_rd(1'b0, 3'd2, 32'd1, "w1c_vs_set");
    set_in(1'b0, 1'b0);
    tick(5);

    // Timeout after the signal stops: last rise + 50 cycles.
    bus_wr(1'b0, 3'd5, 32'd50);
    pulse_train(1'b0, 3, 20);
    tick(32);
    bus_rd(1'b0, 3'd2, 32'd1, "to_before");
    bus_rd(1'b0, 3'd2, 32'd3, "to_set");
    bus_rd(1'b0, 3'd3, 32'd20, "period_hold");
    set_in(1'b0, 1'b1);
    tick(15);
    set_in(1'b0, 1'b0);
    tick(14);
    bus_rd(1'b0, 3'd3, 32'd20, "arm_first_edge");
    set_in(1'b0, 1'b1);
    tick(15);
    set_in(1'b0, 1'b0);
    tick(14);
    bus_rd(1'b0, 3'd3, 32'd30, "period30");

    // Edge-count clear on the same edge as a rise.
    set_in(1'b0, 1'b1);
    tick(2);
    bus_wr(1'b0, 3'd4, 32'd0);
    bus_rd(1'b0, 3'd4, 32'd0, "clr_vs_rise");
    set_in(1'b0, 1'b0);
    tick(4);
    set_in(1'b0, 1'b1);
    tick(4);
    bus_rd(1'b0, 3'd4, 32'd1, "count_after_clr");
    set_in(1'b0, 1'b0);
    tick(4);

    // 4-bit instance: 17 edges wrap to 1, 20-cycle period saturates at 15.
    bus_wr(1'b1, 3'd5, 32'd0);
    bus_wr(1'b1, 3'd1, 32'd1);
    pulse_train(1'b1, 17, 20);
    bus_rd(1'b1, 3'd4, 32'd1, "wrap_b");
    bus_rd(1'b1, 3'd3, 32'd15, "sat_b");

    // Asynchronous reset while measuring.
    set_in(1'b0, 1'b1);
    tick(5);
    check_val("pre_rst_irq", 32'(irq_a), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check_val("async_irq", 32'(irq_a), 32'd0);
    check_val("async_rdata", rdata_a, 32'd0);
    set_in(1'b0, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    bus_rd(1'b0, 3'd1, 32'd0, "post_ctrl");
    bus_rd(1'b0, 3'd5, 32'd0, "post_limit");
    pulse_train(1'b0, 2, 20);
    bus_rd(1'b0, 3'd4, 32'd0, "post_edges");
    bus_rd(1'b0, 3'd3, 32'd0, "post_period");
    bus_rd(1'b0, 3'd2, 32'd0, "post_status");
    check_val("post_irq", 32'(irq_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
